// File: rtl/acc_x_rsp_merge.sv
// Round-robin merge of accelerator response channels into one write-back port,
// with optional splitting of dual write-backs into two single-register beats.
module acc_x_rsp_merge #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumRsp    = 2,
    parameter bit          SplitDual = 1'b1,
    parameter int unsigned IdxWidth  = (NumRsp > 1) ? $clog2(NumRsp) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumRsp-1:0][DataWidth-1:0] inp_data0_i,
    input  logic [NumRsp-1:0][DataWidth-1:0] inp_data1_i,
    input  logic [NumRsp-1:0]                inp_dual_writeback_i,
    input  logic [NumRsp-1:0][4:0]           inp_rd_i,
    input  logic [NumRsp-1:0]                inp_error_i,
    input  logic [NumRsp-1:0]                inp_valid_i,
    output logic [NumRsp-1:0]                inp_ready_o,
    output logic [DataWidth-1:0]             oup_data0_o,
    output logic [DataWidth-1:0]             oup_data1_o,
    output logic                             oup_dual_writeback_o,
    output logic [4:0]                       oup_rd_o,
    output logic                             oup_error_o,
    output logic [IdxWidth-1:0]              oup_src_o,
    output logic                             oup_last_o,
    output logic                             oup_valid_o,
    input  logic                             oup_ready_i
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   ptr_q, ptr_d;
    logic [IdxWidth-1:0]   src_q, src_d;
    logic [DataWidth-1:0]  data0_q, data0_d;
    logic [DataWidth-1:0]  data1_q, data1_d;
    logic                  dual_q, dual_d;
    logic [4:0]            rd_q, rd_d;
    logic                  err_q, err_d;

    logic [IdxWidth:0]     cand;
    logic [IdxWidth-1:0]   win_idx;
    logic                  win_found;
    logic                  beat_last;
    logic                  out_hs;
    logic                  slot_free;
    logic                  accept;
    logic [DataWidth-1:0]  beat_data0;
    logic [4:0]            beat_rd;

    // Search upward from the pointer, wrapping modulo NumRsp.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NumRsp; k++) begin
            cand = {1'b0, ptr_q} + (IdxWidth+1)'(k);
            if (cand >= (IdxWidth+1)'(NumRsp)) begin
                cand = cand - (IdxWidth+1)'(NumRsp);
            end
            if (!win_found && inp_valid_i[cand[IdxWidth-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxWidth-1:0];
            end
        end
    end

    always_comb begin
        beat_last  = (state_q == BEAT1) || !(SplitDual && dual_q);
        beat_data0 = (state_q == BEAT1) ? data1_q : data0_q;
        beat_rd    = (state_q == BEAT1) ? rd_q + 5'd1 : rd_q;
        out_hs     = (state_q != IDLE) && oup_ready_i;
        slot_free  = (state_q == IDLE) || (out_hs && beat_last);
        accept     = win_found && slot_free && !rst_i;
        inp_ready_o = '0;
        if (accept) begin
            inp_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data0_d = data0_q;
        data1_d = data1_q;
        dual_d  = dual_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = BEAT0;
            end
            BEAT0: begin
                if (out_hs) begin
                    if (SplitDual && dual_q) state_d = BEAT1;
                    else if (accept)         state_d = BEAT0;
                    else                     state_d = IDLE;
                end
            end
            BEAT1: begin
                if (out_hs) state_d = accept ? BEAT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            src_d   = win_idx;
            data0_d = inp_data0_i[win_idx];
            data1_d = inp_data1_i[win_idx];
            dual_d  = inp_dual_writeback_i[win_idx];
            rd_d    = inp_rd_i[win_idx];
            err_d   = inp_error_i[win_idx];
            ptr_d   = (32'(win_idx) == NumRsp - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            src_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            dual_q  <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            dual_q  <= dual_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign oup_valid_o          = !rst_i && (state_q != IDLE);
    assign oup_data0_o          = rst_i ? '0 : beat_data0;
    assign oup_data1_o          = (rst_i || SplitDual) ? '0 : data1_q;
    assign oup_dual_writeback_o = !rst_i && !SplitDual && dual_q;
    assign oup_rd_o             = rst_i ? '0 : beat_rd;
    assign oup_error_o          = !rst_i && err_q;
    assign oup_src_o            = rst_i ? '0 : src_q;
    assign oup_last_o           = !rst_i && beat_last;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(inp_ready_o));
    a_no_dual: assert property (@(posedge clk_i)
        !(SplitDual && oup_dual_writeback_o));
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        oup_valid_o && !oup_ready_i |=> oup_valid_o &&
        $stable({oup_data0_o, oup_data1_o, oup_dual_writeback_o,
                 oup_rd_o, oup_error_o, oup_src_o, oup_last_o}));
    for (genvar g = 0; g < NumRsp; g++) begin : g_in_chk
        a_in_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            inp_valid_i[g] && !inp_ready_o[g] |=> inp_valid_i[g] &&
            $stable({inp_data0_i[g], inp_data1_i[g], inp_dual_writeback_i[g],
                     inp_rd_i[g], inp_error_i[g]}));
    end
`endif

endmodule
